// File: rtl/cim_wload_sched.sv
// Weight-load scheduler for a double-banked CIM array: streams rows into the idle bank, then swaps banks once compute releases.
// Optional abort input/aborted output are built in when CIM_WLOAD_ABORT_EN is defined.
module cim_wload_sched #(
    parameter int DW = 24,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   len,
    input  logic          src_valid,
    input  logic [DW-1:0] src_data,
    output logic          src_ready,
    input  logic          cmp_busy,
    output logic          cima,
    output logic [AW-1:0] WA,
    output logic [DW-1:0] D,
    output logic          WE,
    output logic          cmp_bank,
    output logic          busy,
    output logic          done
`ifdef CIM_WLOAD_ABORT_EN
    ,
    input  logic          abort,
    output logic          aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [AW:0] MAX_LEN  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ZERO_LEN = {(AW+1){1'b0}};
    localparam logic [AW:0] ONE_LEN  = {{AW{1'b0}}, 1'b1};

    state_t        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          load_bank_q, load_bank_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          cima_q, cima_d;
    logic          cmp_bank_q, cmp_bank_d;
    logic          done_q, done_d;
    logic          aborted_q, aborted_d;
    logic          busy_q, busy_d;
    logic          src_ready_q, src_ready_d;
    logic          abort_s;
    logic [AW:0]   cnt_next_s;

`ifdef CIM_WLOAD_ABORT_EN
    assign abort_s = abort;
    assign aborted = aborted_q;
`else
    assign abort_s = 1'b0;
`endif

    assign cnt_next_s = cnt_q + ONE_LEN;

    // Next-state and registered-output logic; abort overrides the state move but never a beat's write.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        load_bank_d = load_bank_q;
        we_d        = 1'b0;
        wa_d        = wa_q;
        dat_d       = dat_q;
        cima_d      = cima_q;
        cmp_bank_d  = cmp_bank_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q still high means the previous swap is being reported; busy covers that cycle
                if (start && !done_q && (len != ZERO_LEN)) begin
                    base_d      = base_addr;
                    len_d       = (len > MAX_LEN) ? MAX_LEN : len;
                    load_bank_d = ~cmp_bank_q;
                    cnt_d       = ZERO_LEN;
                    state_d     = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (src_valid) begin
                    we_d   = 1'b1;
                    wa_d   = base_q + cnt_q[AW-1:0];
                    dat_d  = src_data;
                    cima_d = load_bank_q;
                    cnt_d  = cnt_next_s;
                    if (cnt_next_s == len_q) begin
                        state_d = WAIT_SWAP;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    state_d = LOAD;
                end
                if (abort_s) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    aborted_d = 1'b0;
                end
            end
            WAIT_SWAP: begin
                if (abort_s) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (!cmp_busy) begin
                    cmp_bank_d = ~cmp_bank_q;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end else begin
                    state_d = WAIT_SWAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE) || done_d;
        src_ready_d = (state_d == LOAD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            base_q      <= {AW{1'b0}};
            len_q       <= ZERO_LEN;
            cnt_q       <= ZERO_LEN;
            load_bank_q <= 1'b0;
            we_q        <= 1'b0;
            wa_q        <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            cima_q      <= 1'b0;
            cmp_bank_q  <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            busy_q      <= 1'b0;
            src_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            load_bank_q <= load_bank_d;
            we_q        <= we_d;
            wa_q        <= wa_d;
            dat_q       <= dat_d;
            cima_q      <= cima_d;
            cmp_bank_q  <= cmp_bank_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            busy_q      <= busy_d;
            src_ready_q <= src_ready_d;
        end
    end

    assign src_ready = src_ready_q;
    assign cima      = cima_q;
    assign WA        = wa_q;
    assign D         = dat_q;
    assign WE        = we_q;
    assign cmp_bank  = cmp_bank_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_cim_wload_sched.sv
// Directed bench for cim_wload_sched: expected writes are queued as beats are driven and checked when WE appears.
module tb_cim_wload_sched;
    localparam int DW = 24;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n, start, src_valid, cmp_busy;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic [DW-1:0] src_data;
    logic          src_ready, cima, we, cmp_bank, busy, done;
    logic [AW-1:0] wa;
    logic [DW-1:0] d;
`ifdef CIM_WLOAD_ABORT_EN
    logic          abort, aborted;
`endif

    int            checks = 0;
    int            failures = 0;
    logic [32:0]   exp_q[$];
    logic          exp_bank;

    always #5 clk = ~clk;

    cim_wload_sched #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .cmp_busy(cmp_busy), .cima(cima), .WA(wa), .D(d), .WE(we),
        .cmp_bank(cmp_bank), .busy(busy), .done(done)
`ifdef CIM_WLOAD_ABORT_EN
        , .abort(abort), .aborted(aborted)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_cmp();
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("wa", {24'd0, wa}, {24'd0, e[32:25]});
        chk("d", {8'd0, d}, {8'd0, e[24:1]});
        chk("cima", {31'd0, cima}, {31'd0, e[0]});
        chk("bank_excl", {31'd0, cima ^ cmp_bank}, 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"}, {31'd0, src_ready}, 32'd0);
        chk({tag, "_we"}, {31'd0, we}, 32'd0);
        chk({tag, "_wa"}, {24'd0, wa}, 32'd0);
        chk({tag, "_d"}, {8'd0, d}, 32'd0);
        chk({tag, "_cima"}, {31'd0, cima}, 32'd0);
        chk({tag, "_bank"}, {31'd0, cmp_bank}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
    endtask

    // One load: gap alternates valid, hold keeps cmp_busy high after the last beat, rst_at/abort_at cut it short.
    task automatic run_load(input logic [7:0] b, input logic [8:0] l, input int gap,
                            input int hold, input int rst_at, input int abort_at);
        int   eff, k, cyc;
        logic v, prev_v, lb;
        eff = (l > 9'd256) ? 256 : int'(l);
        lb = ~exp_bank;
        base_addr = b; len = l; start = 1'b1; cmp_busy = (hold > 0); src_valid = 1'b0;
        tick();
        start = 1'b0;
        k = 0; cyc = 0; prev_v = 1'b0;
        while (k < eff) begin
            v = (gap == 0) || (cyc % 2 == 0);
            src_valid = v;
            src_data = DW'($urandom);
            if (k == rst_at) rst_n = 1'b0;
`ifdef CIM_WLOAD_ABORT_EN
            if (k == abort_at) abort = 1'b1;
`endif
            @(negedge clk);
            chk("src_ready", {31'd0, src_ready}, 32'd1);
            chk("we_load", {31'd0, we}, {31'd0, prev_v});
            if (prev_v) pop_cmp();
            if (v && k != rst_at) exp_q.push_back({b + k[7:0], src_data, lb});
            if (k == rst_at) begin
                tick();
                src_valid = 1'b0;
                @(negedge clk);
                chk_zero("rst");
                rst_n = 1'b1;
                tick();
                @(negedge clk);
                chk("rst_we_after", {31'd0, we}, 32'd0);
                chk("rst_busy_after", {31'd0, busy}, 32'd0);
                exp_bank = 1'b0;
                return;
            end
`ifdef CIM_WLOAD_ABORT_EN
            if (k == abort_at) begin
                tick();
                abort = 1'b0;
                src_valid = 1'b0;
                @(negedge clk);
                chk("aborted", {31'd0, aborted}, 32'd1);
                chk("abort_we", {31'd0, we}, 32'd1);
                pop_cmp();
                chk("abort_busy", {31'd0, busy}, 32'd0);
                tick();
                @(negedge clk);
                chk("aborted_pulse", {31'd0, aborted}, 32'd0);
                chk("abort_done", {31'd0, done}, 32'd0);
                chk("abort_bank", {31'd0, cmp_bank}, {31'd0, exp_bank});
                return;
            end
`endif
            prev_v = v;
            if (v) k++;
            cyc++;
            tick();
        end
        src_valid = 1'b0;
        @(negedge clk);
        chk("we_last", {31'd0, we}, 32'd1);
        pop_cmp();
        chk("ready_drop", {31'd0, src_ready}, 32'd0);
        chk("busy_wait", {31'd0, busy}, 32'd1);
        chk("done_early", {31'd0, done}, 32'd0);
        if (hold > 0) begin
            start = 1'b1;
            for (int i = 1; i <= hold; i++) begin
                tick();
                if (i == hold) begin
                    cmp_busy = 1'b0;
                    start = 1'b0;
                end
                @(negedge clk);
                chk("hold_done", {31'd0, done}, 32'd0);
                chk("hold_bank", {31'd0, cmp_bank}, {31'd0, exp_bank});
                chk("hold_we", {31'd0, we}, 32'd0);
                chk("hold_busy", {31'd0, busy}, 32'd1);
            end
        end
        tick();
        start = 1'b1; len = 9'd5;
        @(negedge clk);
        chk("done", {31'd0, done}, 32'd1);
        chk("swap_bank", {31'd0, cmp_bank}, {31'd0, ~exp_bank});
        chk("busy_done", {31'd0, busy}, 32'd1);
        chk("we_done", {31'd0, we}, 32'd0);
        exp_bank = ~exp_bank;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ready", {31'd0, src_ready}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; src_valid = 1'b0; cmp_busy = 1'b0;
        base_addr = 8'd0; len = 9'd0; src_data = 24'd0; exp_bank = 1'b0;
`ifdef CIM_WLOAD_ABORT_EN
        abort = 1'b0;
`endif
        tick();
        tick();
        @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        run_load(8'h10, 9'd4, 0, 0, -1, -1);
        run_load(8'hFE, 9'd4, 0, 0, -1, -1);
        run_load(8'h20, 9'd6, 0, 10, -1, -1);
        run_load(8'h30, 9'd4, 1, 0, -1, -1);

        start = 1'b1; len = 9'd0; base_addr = 8'h44;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("len0_busy", {31'd0, busy}, 32'd0);
        chk("len0_ready", {31'd0, src_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("len0_we", {31'd0, we}, 32'd0);

        run_load(8'h00, 9'd300, 0, 0, -1, -1);
        run_load(8'h40, 9'd8, 0, 0, 2, -1);
`ifdef CIM_WLOAD_ABORT_EN
        run_load(8'h50, 9'd8, 0, 0, -1, 3);
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cim_wload_sched.md
CIM_WLOAD_SCHED -- requirements
Module: cim_wload_sched

Interface
REQ-001 SHALL have parameters: DW, default 24, weight row width; AW, default 8, row address width.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  load-request pulse.
- base_addr  in  AW  first row to write.
- len  in  AW+1  number of rows to write.
- src_valid  in  1  weight stream valid.
- src_data  in  DW  weight stream data.
- src_ready  out  1  weight stream ready.
- cmp_busy  in  1  compute engine is using the active bank.
- cima  out  1  bank select for the write path.
- WA  out  AW  write row address.
- D  out  DW  write data.
- WE  out  1  write strobe.
- cmp_bank  out  1  bank owned by compute.
- busy  out  1  scheduler not in IDLE.
- done  out  1  load-and-swap complete pulse.
- abort, aborted: only when CIM_WLOAD_ABORT_EN is defined (see REQ-019).
REQ-003 SHALL have one clock and a synchronous active-low reset rst_n; reset is sampled only on the rising edge of clk.

Function
REQ-004 SHALL implement the FSM states IDLE, LOAD and WAIT_SWAP; busy SHALL be 1 in every state except IDLE.
REQ-005 In IDLE, start=1 with len!=0 SHALL latch base_addr and len, set load bank = ~cmp_bank, clear the beat count, and enter LOAD next cycle.
REQ-006 start with len==0 SHALL be ignored; start while busy=1 SHALL be ignored.
REQ-007 A len value above 2^AW SHALL be clamped to 2^AW (256 at default).
REQ-008 src_ready SHALL equal 1 exactly when state==LOAD; a beat transfers when src_valid&&src_ready.
REQ-009 Each transferred beat k (0-based) SHALL produce, on the next cycle only:
- WE=1
- D=src_data
- WA=(base_addr+k) mod 2^AW, wrapping from 255 to 0.
- cima=load bank.
REQ-010 WE SHALL be 0 in every cycle not covered by REQ-009; WA, D and cima SHALL hold their last values while WE=0.
REQ-011 cima SHALL never equal cmp_bank while WE=1.
REQ-012 After the beat that makes count equal len, the FSM SHALL enter WAIT_SWAP next cycle and src_ready SHALL drop in that same cycle.
REQ-013 In WAIT_SWAP with cmp_busy=0, the scheduler SHALL:
- toggle cmp_bank;
- pulse done for exactly 1 cycle;
- return to IDLE.
All three take effect in the following cycle.
REQ-014 In WAIT_SWAP with cmp_busy=1, the FSM SHALL hold, with cmp_bank unchanged and no writes issued.
REQ-015 A start in the same cycle done=1 SHALL be ignored, since busy is still 1 in that cycle.
REQ-016 Latency from start to the first WE, with src_valid held at 1, SHALL be 2 cycles.

Reset
REQ-017 While rst_n=0, all outputs SHALL be 0 on the next rising edge:
- state=IDLE, src_ready=0, WE=0, WA=0, D=0;
- cima=0, cmp_bank=0, busy=0, done=0, aborted=0.
REQ-018 A reset asserted mid-LOAD or mid-WAIT_SWAP SHALL discard the operation with no swap, and no WE SHALL be issued after the reset edge.

Configuration
REQ-019 Macro CIM_WLOAD_ABORT_EN:
- When defined: add input abort and output aborted. abort=1 in LOAD or WAIT_SWAP SHALL return the FSM to IDLE next cycle, leave cmp_bank unchanged, pulse aborted for 1 cycle, and suppress done.
- Abort takes priority over a simultaneous beat or swap; the beat's WE is still issued.
- When undefined: both ports SHALL be absent and the behaviour SHALL be as in REQ-004..REQ-018.

Verification
REQ-020 Basic load: base=0x10, len=4, src_valid=1, cmp_busy=0 -> WE at WA 0x10..0x13 with cima=1, done 1 cycle later, cmp_bank becomes 1.
REQ-021 Wrap: base=0xFE, len=4 -> WA sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-022 Swap hold: cmp_busy=1 for 10 cycles after the last beat -> state stays WAIT_SWAP, cmp_bank is stable, done appears 1 cycle after cmp_busy falls.
REQ-023 Backpressure and ignores: src_valid toggling 1,0,1,0 -> WE only after valid beats. start during busy is ignored. len=0 is ignored. len=300 -> exactly 256 writes.
REQ-024 Reset and abort:
- rst_n=0 at beat 2 of 8 -> all outputs 0, no further WE, cmp_bank=0.
- With CIM_WLOAD_ABORT_EN, abort at beat 3 -> aborted pulse, no done, cmp_bank unchanged.
